// File: rtl/sram_rw_port_ctrl_pkg.sv
// Shared types and constants for the SRAM RW-port controller.
package sram_rw_port_ctrl_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } ctrl_state_e;

   localparam int unsigned RESP_FIFO_DEPTH = 3;

endpackage

// File: rtl/sram_rw_port_ctrl_resp_fifo.sv
// Small response FIFO holding captured read data; head is presented from storage.
module sram_resp_fifo
   import sram_rw_port_ctrl_pkg::*;
#(
   parameter  int unsigned WIDTH = 60,
   parameter  int unsigned DEPTH = RESP_FIFO_DEPTH,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_valid,
   output logic [CNT_W-1:0] o_count
);

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_pop;

   assign w_pop   = i_pop && (r_count != '0);
   assign o_valid = (r_count != '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

endmodule

// File: rtl/sram_rw_port_ctrl.sv
// Initiator-side controller for a 1-cycle-latency single-port SRAM: optional
// zero-fill after reset, valid/ready requests in, ordered read responses out.
module sram_rw_port_ctrl
   import sram_rw_port_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W        = 12,
   parameter int unsigned DATA_W        = 60,
   parameter int unsigned MASK_W        = 10,
   parameter int unsigned DEPTH         = 4096,
   parameter bit          INIT_ON_RESET = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wmode,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [MASK_W-1:0] req_wmask,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              init_done,
   output logic              sram_en,
   output logic              sram_wmode,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [MASK_W-1:0] sram_wmask,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
);

   localparam int unsigned       CNT_W       = $clog2(RESP_FIFO_DEPTH + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
   localparam ctrl_state_e       RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_RUN;

   ctrl_state_e       r_state;
   ctrl_state_e       w_state_nxt;
   logic [ADDR_W-1:0] r_init_addr;
   logic              r_init_done;
   logic              r_rd_inflight;
   logic [CNT_W-1:0]  w_fifo_count;
   logic [CNT_W:0]    w_occupancy;
   logic              w_init_last;
   logic              w_req_ready;
   logic              w_fire;

   assign w_init_last = (r_init_addr == LAST_ADDR);
   // In-flight read reserves its FIFO slot so the unconditional capture never overflows.
   assign w_occupancy = (CNT_W + 1)'(w_fifo_count) + (CNT_W + 1)'(r_rd_inflight);
   assign req_ready   = w_req_ready;
   assign init_done   = r_init_done;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= RESET_STATE;
         r_init_addr   <= '0;
         r_init_done   <= !INIT_ON_RESET;
         r_rd_inflight <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_rd_inflight <= w_fire && !req_wmode;
         if (r_state == ST_INIT) begin
            r_init_addr <= r_init_addr + 1'b1;
            if (w_init_last) begin
               r_init_done <= 1'b1;
            end
         end
      end
   end

   // The macro port is gated by the live reset level so it stays idle while reset is held.
   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = 1'b0;
      w_fire      = 1'b0;
      sram_en     = 1'b0;
      sram_wmode  = req_wmode;
      sram_addr   = req_addr;
      sram_wmask  = req_wmask;
      sram_wdata  = req_wdata;
      case (r_state)
         ST_INIT: begin
            sram_en    = reset;
            sram_wmode = 1'b1;
            sram_addr  = r_init_addr;
            sram_wmask = '1;
            sram_wdata = '0;
            if (w_init_last) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_req_ready = reset && (w_occupancy < (CNT_W + 1)'(RESP_FIFO_DEPTH));
            w_fire      = req_valid && w_req_ready;
            sram_en     = w_fire;
         end
         default: w_state_nxt = RESET_STATE;
      endcase
   end

   sram_resp_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (RESP_FIFO_DEPTH)
   ) u_resp_fifo (
      .i_clk   (clock),
      .i_rst_n (reset),
      .i_push  (r_rd_inflight),
      .i_wdata (sram_rdata),
      .i_pop   (resp_ready),
      .o_rdata (resp_rdata),
      .o_valid (resp_valid),
      .o_count (w_fifo_count)
   );

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Directed bench for sram_rw_port_ctrl with a behavioural 1-cycle-latency SRAM macro.
module tb_sram_rw_port_ctrl;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DATA_W = 60;
   localparam int unsigned MASK_W = 10;
   localparam int unsigned DEPTH  = 4096;
   localparam int unsigned LANE_W = DATA_W / MASK_W;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_wmode = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [MASK_W-1:0] req_wmask = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic              resp_valid;
   logic              resp_ready = 1'b0;
   logic [DATA_W-1:0] resp_rdata;
   logic              init_done;
   logic              sram_en;
   logic              sram_wmode;
   logic [ADDR_W-1:0] sram_addr;
   logic [MASK_W-1:0] sram_wmask;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata = '0;

   int n_checks = 0;
   int n_fail   = 0;
   logic [DATA_W-1:0] resp_q [$];

   always #5 clock = ~clock;

   sram_rw_port_ctrl #(
      .ADDR_W        (ADDR_W),
      .DATA_W        (DATA_W),
      .MASK_W        (MASK_W),
      .DEPTH         (DEPTH),
      .INIT_ON_RESET (1'b1)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wmode  (req_wmode),
      .req_addr   (req_addr),
      .req_wmask  (req_wmask),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .init_done  (init_done),
      .sram_en    (sram_en),
      .sram_wmode (sram_wmode),
      .sram_addr  (sram_addr),
      .sram_wmask (sram_wmask),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   // Macro model: lane-masked write, registered read data.
   logic [DATA_W-1:0] mem [DEPTH];

   function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [MASK_W-1:0] m);
      logic [DATA_W-1:0] r = old_w;
      for (int l = 0; l < MASK_W; l++)
         if (m[l]) r[l*LANE_W +: LANE_W] = new_w[l*LANE_W +: LANE_W];
      return r;
   endfunction

   always @(posedge clock) begin
      if (sram_en) begin
         if (sram_wmode) mem[sram_addr] <= merge_lanes(mem[sram_addr], sram_wdata, sram_wmask);
         else            sram_rdata     <= mem[sram_addr];
      end
   end

   task automatic tick;
      @(posedge clock); #1;
   endtask

   task automatic issue(input logic wm, input logic [ADDR_W-1:0] a, input logic [MASK_W-1:0] m,
                        input logic [DATA_W-1:0] d, output bit ok);
      ok = 1'b0;
      req_valid = 1'b1; req_wmode = wm; req_addr = a; req_wmask = m; req_wdata = d;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clock);
         ok = req_ready;
         tick();
      end
      req_valid = 1'b0;
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] data, output bit ok);
      bit iok;
      ok = 1'b0; data = '0; resp_ready = 1'b1;
      issue(1'b0, a, '0, '0, iok);
      if (iok) begin
         for (int c = 0; c < 8 && !ok; c++) begin
            @(negedge clock);
            if (resp_valid) begin data = resp_rdata; ok = 1'b1; end
            tick();
         end
      end
   endtask

   task automatic run_stream(input bit wm, input logic [ADDR_W-1:0] base, input int n,
                             input logic [DATA_W-1:0] dbase, input int exp_resp, input int max_cyc,
                             output int fires, output int stalls);
      bit f;
      resp_q.delete(); fires = 0; stalls = 0;
      req_valid = (n > 0); req_wmode = wm; req_addr = base; req_wmask = '1; req_wdata = dbase;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clock);
         f = req_valid && req_ready;
         if (req_valid && !req_ready) stalls++;
         if (resp_valid && resp_ready) resp_q.push_back(resp_rdata);
         tick();
         if (f) begin
            fires++;
            if (fires == n) req_valid = 1'b0;
            else begin
               req_addr  = base + ADDR_W'(fires);
               req_wdata = dbase + DATA_W'(fires);
            end
         end
         if (fires == n && resp_q.size() == exp_resp) break;
      end
      req_valid = 1'b0;
   endtask

   task automatic test_init_sweep(input string tag);
      int bad = 0;
      int first_bad = -1;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clock);
         if (!(sram_en === 1'b1 && sram_wmode === 1'b1 && sram_wmask === '1 && sram_wdata === '0 &&
               sram_addr === ADDR_W'(i) && req_ready === 1'b0 && init_done === 1'b0)) begin
            if (bad == 0) first_bad = i;
            bad++;
         end
         tick();
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL %s_sweep: %0d bad cycles (first at %0d, addr=%h en=%b) required 0", tag, bad, first_bad, sram_addr, sram_en);
      end
      @(negedge clock);
      n_checks++;
      if (init_done !== 1'b1) begin n_fail++; $display("FAIL %s_init_done: got %b required 1", tag, init_done); end
      n_checks++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s_req_ready: got %b required 1", tag, req_ready); end
      n_checks++;
      if (sram_en !== 1'b0) begin n_fail++; $display("FAIL %s_idle_en: got %b required 0", tag, sram_en); end
      tick();
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) tick();
      @(negedge clock);
      n_checks++; if (req_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_req_ready: got %b required 0", req_ready); end
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b required 0", resp_valid); end
      n_checks++; if (init_done !== 1'b0)  begin n_fail++; $display("FAIL rst_init_done: got %b required 0", init_done); end
      n_checks++; if (sram_en !== 1'b0)    begin n_fail++; $display("FAIL rst_sram_en: got %b required 0", sram_en); end
      tick();
      reset = 1'b1;
      test_init_sweep("init");
   endtask

   task automatic test_init_read;
      logic [DATA_W-1:0] d;
      bit ok;
      logic [ADDR_W-1:0] addrs [3] = '{12'h7FF, 12'h000, 12'hFFF};
      for (int k = 0; k < 3; k++) begin
         do_read(addrs[k], d, ok);
         n_checks++;
         if (!ok || d !== '0) begin
            n_fail++;
            $display("FAIL init_read_%h: got %h (ok=%b) required 0", addrs[k], d, ok);
         end
      end
   endtask

   task automatic test_write_read;
      resp_ready = 1'b0;
      req_valid = 1'b1; req_wmode = 1'b1; req_addr = 12'h010; req_wmask = 10'h3FF; req_wdata = 60'hABCDEF;
      @(negedge clock);
      n_checks++;
      if (sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_addr !== 12'h010) begin
         n_fail++; $display("FAIL wr_issue: got en=%b wm=%b addr=%h required 1 1 010", sram_en, sram_wmode, sram_addr);
      end
      tick();
      req_wmode = 1'b0;
      @(negedge clock);
      n_checks++;
      if (req_ready !== 1'b1 || sram_en !== 1'b1 || sram_wmode !== 1'b0) begin
         n_fail++; $display("FAIL rd_issue: got ready=%b en=%b wm=%b required 1 1 0", req_ready, sram_en, sram_wmode);
      end
      tick();
      req_valid = 1'b0;
      @(negedge clock);
      n_checks++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_lat_n1: got resp_valid=%b required 0", resp_valid); end
      tick();
      @(negedge clock);
      n_checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 60'hABCDEF) begin
         n_fail++; $display("FAIL rd_lat_n2: got valid=%b data=%h required 1 abcdef", resp_valid, resp_rdata);
      end
      resp_ready = 1'b1;
      tick();
      @(negedge clock);
      n_checks++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_pop: got resp_valid=%b required 0", resp_valid); end
      tick();
   endtask

   task automatic test_partial_mask;
      logic [DATA_W-1:0] d;
      bit ok, ok1, ok2;
      issue(1'b1, 12'h020, 10'h3FF, 60'h0FFFFFFFFFFFFFFF, ok1);
      issue(1'b1, 12'h020, 10'h001, 60'h0, ok2);
      do_read(12'h020, d, ok);
      n_checks++;
      if (!(ok && ok1 && ok2) || d !== 60'h0FFFFFFFFFFFFFC0) begin
         n_fail++; $display("FAIL partial_mask: got %h required 0fffffffffffffc0", d);
      end
      issue(1'b1, 12'h020, 10'h000, 60'h123456789ABCDEF, ok1);
      do_read(12'h020, d, ok);
      n_checks++;
      if (!(ok && ok1) || d !== 60'h0FFFFFFFFFFFFFC0) begin
         n_fail++; $display("FAIL zero_mask: got %h required 0fffffffffffffc0", d);
      end
   endtask

   task automatic test_backpressure;
      int fires = 0, f2, s, bad = 0;
      bit f;
      run_stream(1'b1, 12'h100, 5, 60'h1000, 0, 40, f2, s);
      resp_ready = 1'b0;
      req_valid = 1'b1; req_wmode = 1'b0; req_addr = 12'h100;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         f = req_valid && req_ready;
         tick();
         if (f) begin fires++; req_addr = 12'h100 + ADDR_W'(fires); end
      end
      @(negedge clock);
      n_checks++;
      if (fires != 3) begin n_fail++; $display("FAIL bp_accepted: got %0d required 3", fires); end
      n_checks++;
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b required 0", req_ready); end
      n_checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 60'h1000) begin
         n_fail++; $display("FAIL bp_head: got valid=%b data=%h required 1 1000", resp_valid, resp_rdata);
      end
      tick();
      resp_ready = 1'b1;
      run_stream(1'b0, 12'h103, 2, '0, 5, 30, f2, s);
      n_checks++;
      if (f2 != 2) begin n_fail++; $display("FAIL bp_remaining: got %0d required 2", f2); end
      if (resp_q.size() != 5) bad = 99;
      else for (int k = 0; k < 5; k++) if (resp_q[k] !== 60'h1000 + DATA_W'(k)) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL bp_order: got %0d responses with %0d wrong required 5 in order", resp_q.size(), bad); end
   endtask

   task automatic test_streaming;
      int fires, stalls, bad = 0;
      run_stream(1'b1, 12'h200, 100, 60'hC0DE0000, 0, 300, fires, stalls);
      resp_ready = 1'b1;
      run_stream(1'b0, 12'h200, 100, '0, 100, 300, fires, stalls);
      n_checks++;
      if (fires != 100) begin n_fail++; $display("FAIL stream_fires: got %0d required 100", fires); end
      n_checks++;
      if (stalls != 0) begin n_fail++; $display("FAIL stream_stalls: got %0d required 0", stalls); end
      if (resp_q.size() != 100) bad = 999;
      else for (int k = 0; k < 100; k++) if (resp_q[k] !== 60'hC0DE0000 + DATA_W'(k)) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL stream_order: got %0d responses with %0d wrong required 100 in order", resp_q.size(), bad); end
   endtask

   task automatic test_reset_mid;
      int fires, stalls;
      logic [DATA_W-1:0] d;
      bit ok;
      resp_ready = 1'b0;
      run_stream(1'b0, 12'h100, 2, '0, 0, 10, fires, stalls);
      tick(); tick();
      @(negedge clock);
      n_checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 60'h1000) begin
         n_fail++; $display("FAIL mid_queued: got valid=%b data=%h required 1 1000", resp_valid, resp_rdata);
      end
      tick();
      reset = 1'b0;
      #1;
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_resp_valid: got %b required 0", resp_valid); end
      n_checks++; if (req_ready !== 1'b0)  begin n_fail++; $display("FAIL mid_req_ready: got %b required 0", req_ready); end
      n_checks++; if (init_done !== 1'b0)  begin n_fail++; $display("FAIL mid_init_done: got %b required 0", init_done); end
      n_checks++; if (sram_en !== 1'b0)    begin n_fail++; $display("FAIL mid_sram_en: got %b required 0", sram_en); end
      tick(); tick();
      reset = 1'b1;
      test_init_sweep("reinit");
      @(negedge clock);
      n_checks++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_resp: got %b required 0", resp_valid); end
      tick();
      do_read(12'h100, d, ok);
      n_checks++;
      if (!ok || d !== '0) begin n_fail++; $display("FAIL mid_rezeroed: got %h (ok=%b) required 0", d, ok); end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_init_read();
      test_write_read();
      test_partial_mask();
      test_backpressure();
      test_streaming();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
